// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and helpers for the hazard scoreboard
//
// Purpose: scoreboard entry type, select-width helper and the bubble value
//          used by hazard_scoreboard and sb_match.
// Contents:
//   SB_RD_MAX_W  widest register address an entry can hold
//   sb_entry_t   {valid, rd, regWrite, isLoad}
//   sel_width()  bits needed to encode 0..numStages
//   SB_BUBBLE    the empty entry shifted in when nothing issues
package hazard_pkg;

  // Entries hold rd zero-extended to this width, so REG_ADDR_W must not exceed it.
  localparam int SB_RD_MAX_W = 8;

  typedef struct packed {
    logic                   valid;
    logic [SB_RD_MAX_W-1:0] rd;
    logic                   regWrite;
    logic                   isLoad;
  } sb_entry_t;

  // Width of a forwarding select: codes 0 (register file) through numStages.
  function automatic int sel_width(input int numStages);
    int w;
    w = 1;
    while ((1 << w) < (numStages + 1)) begin
      w = w + 1;
    end
    return w;
  endfunction

  localparam sb_entry_t SB_BUBBLE = '0;

endpackage

// File: rtl/hazard_scoreboard_sb_match.sv
// rtl/hazard_scoreboard_sb_match.sv - priority matcher of one source operand against the scoreboard
//
// Purpose: finds the youngest live scoreboard entry whose rd equals src.
// Ports:
//   src      in   REG_ADDR_W       source register address
//   srcUsed  in   1                operand is actually read
//   idValid  in   1                RF stage holds a real instruction
//   entries  in   NUM_STAGES x sb  scoreboard, index 0 youngest
//   hit      out  1                a live entry matches
//   index    out  IDX_W            index of the winning entry
//   isLoad   out  1                winning entry is a load
module sb_match
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_STAGES = 3,
  parameter int ZERO_REG   = 31,
  parameter int IDX_W      = 2
) (
  input  logic [REG_ADDR_W-1:0]            src,
  input  logic                             srcUsed,
  input  logic                             idValid,
  input  sb_entry_t [NUM_STAGES-1:0]       entries,
  output logic                             hit,
  output logic [IDX_W-1:0]                 index,
  output logic                             isLoad
);

  logic [SB_RD_MAX_W-1:0] srcExt;
  logic [SB_RD_MAX_W-1:0] zeroExt;

  assign srcExt  = SB_RD_MAX_W'(src);
  assign zeroExt = SB_RD_MAX_W'(ZERO_REG);

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    hit    = 1'b0;
    index  = '0;
    isLoad = 1'b0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (idValid && srcUsed &&
          entries[k].valid && entries[k].regWrite &&
          (entries[k].rd != zeroExt) && (entries[k].rd == srcExt)) begin
        hit    = 1'b1;
        index  = IDX_W'(k);
        isLoad = entries[k].isLoad;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - forwarding select and load-use hazard controller for the LEGv8 pipe
//
// Purpose: tracks in-flight register writes across NUM_STAGES post-decode
//          stages, selects a forwarding source per operand and inserts a
//          bubble on load-use hazards. Keeps saturating stall/bubble counters.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   id_*              RF-stage instruction: valid, rd, reg_write, is_load,
//                     packed sources and per-source used bits
//   flush             kill the RF instruction
//   hold              freeze the whole pipe
//   stall             hold PC and IF/RF registers (hazard or hold)
//   fwd_sel           per-operand select, 0 = RF, k+1 = stage k result
//   stage_valid       scoreboard valid bits
//   stall_cnt         load-use stall cycles, saturating
//   bubble_cnt        bubbles entered into stage 0, saturating
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_STAGES = 3,
  parameter int NUM_SRC    = 2,
  parameter int LOAD_READY = 1,
  parameter int ZERO_REG   = 31,
  parameter int CNT_W      = 16,
  localparam int SEL_W     = sel_width(NUM_STAGES)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          id_valid,
  input  logic [REG_ADDR_W-1:0]         id_rd,
  input  logic                          id_reg_write,
  input  logic                          id_is_load,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]            id_src_used,
  input  logic                          flush,
  input  logic                          hold,
  output logic                          stall,
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
  output logic [NUM_STAGES-1:0]         stage_valid,
  output logic [CNT_W-1:0]              stall_cnt,
  output logic [CNT_W-1:0]              bubble_cnt
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  // One extra bit so LOAD_READY == NUM_STAGES still compares correctly.
  localparam logic [IDX_W:0] LOAD_READY_V = (IDX_W + 1)'(LOAD_READY);

  sb_entry_t [NUM_STAGES-1:0] sbQ;

  logic [NUM_SRC-1:0] hitVec;
  logic [NUM_SRC-1:0] loadVec;
  logic [NUM_SRC-1:0] useHazVec;
  logic [IDX_W-1:0]   idxArr [NUM_SRC];

  logic      hazard;
  logic      issue;
  sb_entry_t newEntry;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      sb_match #(
        .REG_ADDR_W (REG_ADDR_W),
        .NUM_STAGES (NUM_STAGES),
        .ZERO_REG   (ZERO_REG),
        .IDX_W      (IDX_W)
      ) u_match (
        .src     (id_src[gi*REG_ADDR_W +: REG_ADDR_W]),
        .srcUsed (id_src_used[gi]),
        .idValid (id_valid),
        .entries (sbQ),
        .hit     (hitVec[gi]),
        .index   (idxArr[gi]),
        .isLoad  (loadVec[gi])
      );

      // A load whose data is not yet out of its stage cannot be forwarded.
      assign useHazVec[gi] = hitVec[gi] & loadVec[gi] &
                             ({1'b0, idxArr[gi]} < LOAD_READY_V);

      assign fwd_sel[gi*SEL_W +: SEL_W] =
        hitVec[gi] ? (SEL_W'(idxArr[gi]) + SEL_W'(1)) : '0;
    end
  endgenerate

  assign hazard = |useHazVec;
  assign stall  = hazard | hold;

  // Flush wins over hazard; either way a bubble enters stage 0.
  assign issue = id_valid & ~hazard & ~flush;

  always_comb begin
    newEntry = SB_BUBBLE;
    if (issue) begin
      newEntry.valid    = 1'b1;
      newEntry.rd       = SB_RD_MAX_W'(id_rd);
      newEntry.regWrite = id_reg_write;
      newEntry.isLoad   = id_is_load;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        sbQ[k] <= SB_BUBBLE;
      end
    end else if (!hold) begin
      for (int k = NUM_STAGES - 1; k >= 1; k--) begin
        sbQ[k] <= sbQ[k-1];
      end
      sbQ[0] <= newEntry;
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_STAGES; k++) begin
      stage_valid[k] = sbQ[k].valid;
    end
  end

  // Counters only move on advance cycles and stick at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (!hold) begin
      if (hazard && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (!issue && (bubble_cnt != '1)) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - randomized and directed bench for hazard_scoreboard
module tb_hazard_scoreboard;

  localparam int NS  = 3;
  localparam int LR  = 1;
  localparam int ZR  = 31;

  logic       clk = 1'b0;
  logic       reset;
  logic       idValid;
  logic [4:0] idRd;
  logic       idRegWrite;
  logic       idIsLoad;
  logic [9:0] idSrc;
  logic [1:0] idSrcUsed;
  logic       flush;
  logic       hold;

  logic        stall, stallSat;
  logic [3:0]  fwdSel, fwdSelSat;
  logic [2:0]  stageValid, stageValidSat;
  logic [15:0] stallCnt, bubbleCnt;
  logic [1:0]  stallCntSat, bubbleCntSat;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset), .id_valid(idValid), .id_rd(idRd),
    .id_reg_write(idRegWrite), .id_is_load(idIsLoad), .id_src(idSrc),
    .id_src_used(idSrcUsed), .flush(flush), .hold(hold), .stall(stall),
    .fwd_sel(fwdSel), .stage_valid(stageValid), .stall_cnt(stallCnt),
    .bubble_cnt(bubbleCnt)
  );

  hazard_scoreboard #(.CNT_W(2)) dutSat (
    .clk(clk), .reset(reset), .id_valid(idValid), .id_rd(idRd),
    .id_reg_write(idRegWrite), .id_is_load(idIsLoad), .id_src(idSrc),
    .id_src_used(idSrcUsed), .flush(flush), .hold(hold), .stall(stallSat),
    .fwd_sel(fwdSelSat), .stage_valid(stageValidSat), .stall_cnt(stallCntSat),
    .bubble_cnt(bubbleCntSat)
  );

  // Reference: list of the last NS issued slots, youngest first.
  typedef struct {
    bit valid;
    int rd;
    bit rw;
    bit ld;
  } rec_t;

  rec_t pipe[$];
  int   mStalls;
  int   mBubbles;

  task automatic checkVal(input string tag, input int unsigned got, input int unsigned exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int modelSel(input int src, input bit used);
    if (!idValid || !used) return 0;
    for (int k = 0; k < NS; k++) begin
      if (pipe[k].valid && pipe[k].rw && pipe[k].rd != ZR && pipe[k].rd == src)
        return k + 1;
    end
    return 0;
  endfunction

  function automatic bit modelHazard();
    int s[2];
    s[0] = modelSel(int'(idSrc[4:0]), idSrcUsed[0]);
    s[1] = modelSel(int'(idSrc[9:5]), idSrcUsed[1]);
    for (int i = 0; i < 2; i++)
      if (s[i] > 0 && pipe[s[i]-1].ld && (s[i] - 1) < LR) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic modelReset();
    rec_t e;
    e = '{valid: 1'b0, rd: 0, rw: 1'b0, ld: 1'b0};
    pipe.delete();
    for (int k = 0; k < NS; k++) pipe.push_back(e);
    mStalls  = 0;
    mBubbles = 0;
  endtask

  task automatic compareAll();
    int unsigned sv;
    bit haz;
    haz = modelHazard();
    sv = 0;
    for (int k = 0; k < NS; k++) if (pipe[k].valid) sv |= (1 << k);
    checkVal("stall",      stall, haz | hold);
    checkVal("fwd0",       fwdSel[1:0], modelSel(int'(idSrc[4:0]), idSrcUsed[0]));
    checkVal("fwd1",       fwdSel[3:2], modelSel(int'(idSrc[9:5]), idSrcUsed[1]));
    checkVal("stageValid", stageValid, sv);
    checkVal("stallCnt",   stallCnt, sat(mStalls, 65535));
    checkVal("bubbleCnt",  bubbleCnt, sat(mBubbles, 65535));
    checkVal("satStall",   stallCntSat, sat(mStalls, 3));
    checkVal("satBubble",  bubbleCntSat, sat(mBubbles, 3));
  endtask

  // Drive at the falling edge and compare the combinational outputs shortly after.
  task automatic setIn(input bit v, input int rd, input bit rw, input bit ld,
                       input int s0, input int s1, input bit [1:0] used,
                       input bit fl, input bit hd, input bit rst);
    @(negedge clk);
    idValid    = v;
    idRd       = 5'(rd);
    idRegWrite = rw;
    idIsLoad   = ld;
    idSrc      = {5'(s1), 5'(s0)};
    idSrcUsed  = used;
    flush      = fl;
    hold       = hd;
    reset      = rst;
    #2;
    compareAll();
  endtask

  task automatic tick();
    rec_t e;
    bit haz;
    @(posedge clk);
    if (reset) begin
      modelReset();
    end else if (!hold) begin
      haz = modelHazard();
      e.valid = idValid && !haz && !flush;
      e.rd    = int'(idRd);
      e.rw    = idRegWrite;
      e.ld    = idIsLoad;
      pipe.push_front(e);
      void'(pipe.pop_back());
      if (haz) mStalls++;
      if (!e.valid) mBubbles++;
    end
  endtask

  task automatic idle();
    setIn(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    tick();
  endtask

  int regs[5] = '{0, 1, 2, 3, 31};

  initial begin
    idValid = 0; idRd = 0; idRegWrite = 0; idIsLoad = 0;
    idSrc = 0; idSrcUsed = 0; flush = 0; hold = 0; reset = 1;
    repeat (2) @(posedge clk);
    modelReset();

    setIn(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    checkVal("rstStageValid", stageValid, 0);
    checkVal("rstBubbleCnt", bubbleCnt, 0);
    tick();

    // ADDI X1 then ADD X2,X1,X3 then an independent use of X1.
    setIn(1, 1, 1, 0, 2, 31, 2'b01, 0, 0, 0); tick();
    setIn(1, 2, 1, 0, 1, 3, 2'b11, 0, 0, 0);
    checkVal("addFwd", fwdSel[1:0], 1);
    tick();
    setIn(1, 4, 1, 0, 1, 0, 2'b01, 0, 0, 0);
    checkVal("addFwdLater", fwdSel[1:0], 2);
    tick();

    // LDUR X1 then ADD X2,X1,X1: one stall, then both from stage 1.
    setIn(1, 1, 1, 1, 0, 0, 2'b00, 0, 0, 0); tick();
    setIn(1, 2, 1, 0, 1, 1, 2'b11, 0, 0, 0);
    checkVal("ldStall", stall, 1);
    checkVal("ldFwd", fwdSel, 4'b0101);
    tick();
    setIn(1, 2, 1, 0, 1, 1, 2'b11, 0, 0, 0);
    checkVal("ldStallDone", stall, 0);
    checkVal("ldFwdDone", fwdSel, 4'b1010);
    tick();

    // Zero register and unused operand never forward.
    setIn(1, 31, 1, 1, 0, 0, 2'b00, 0, 0, 0); tick();
    setIn(1, 5, 1, 0, 31, 31, 2'b11, 0, 0, 0);
    checkVal("zeroReg", fwdSel, 0);
    tick();
    setIn(1, 6, 1, 0, 5, 5, 2'b00, 0, 0, 0);
    checkVal("unused", fwdSel, 0);
    tick();

    // Flush during load-use hazard.
    setIn(1, 7, 1, 1, 0, 0, 2'b00, 0, 0, 0); tick();
    setIn(1, 8, 1, 0, 7, 0, 2'b01, 1, 0, 0); tick();
    setIn(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    checkVal("flushBubble", stageValid[0], 0);
    tick();

    // Hold for three cycles with a load in stage 0, then release.
    setIn(1, 9, 1, 1, 0, 0, 2'b00, 0, 0, 0); tick();
    repeat (3) begin
      setIn(1, 10, 1, 0, 9, 0, 2'b01, 0, 1, 0); tick();
    end
    setIn(1, 10, 1, 0, 9, 0, 2'b01, 0, 0, 0); tick();
    setIn(1, 10, 1, 0, 9, 0, 2'b01, 0, 0, 0);
    checkVal("holdRelease", stall, 0);
    tick();

    // Reset mid-stall.
    setIn(1, 11, 1, 1, 0, 0, 2'b00, 0, 0, 0); tick();
    setIn(1, 12, 1, 0, 11, 0, 2'b01, 0, 0, 1); tick();
    setIn(1, 12, 1, 0, 11, 0, 2'b01, 0, 0, 0);
    checkVal("rstMidStall", stall, 0);
    checkVal("rstStallCnt", stallCnt, 0);
    tick();

    // Saturation of the narrow counter.
    repeat (5) idle();
    setIn(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    checkVal("bubbleSat", bubbleCntSat, 3);
    tick();

    // Random traffic over a small register set to provoke matches.
    for (int n = 0; n < 600; n++) begin
      setIn($urandom_range(0, 3) != 0,
            regs[$urandom_range(0, 4)], $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0,
            regs[$urandom_range(0, 4)], regs[$urandom_range(0, 4)],
            2'($urandom_range(0, 3)),
            $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 49) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding controller for the pipelined LEGv8 core. It tracks in-flight register writes across NUM_STAGES post-decode stages and produces a per-source-operand forwarding select for the RF stage. It also detects load-use hazards, inserting a one-cycle bubble rather than relying on a fixed EX/MEM mux. It supports an external whole-pipe hold and a decode-stage flush, and keeps saturating stall and bubble counters for performance analysis.

## Interface
Parameters:
- REG_ADDR_W, 5, register address width.
- NUM_STAGES, 3, tracked stages after RF; index 0 = EX, 1 = MEM, 2 = WB.
- NUM_SRC, 2, source operands checked per decoded instruction.
- LOAD_READY, 1, first stage index whose output carries load data.
- ZERO_REG, 31, register that reads zero and is never a forwarding source.
- CNT_W, 16, performance counter width.

Ports:
- Single clock and reset: `clk` and `reset`. Reset is synchronous and active-high.
- clk, in, 1: clock.
- reset, in, 1: synchronous active-high reset.
- id_valid, in, 1: RF stage holds a real instruction.
- id_rd, in, REG_ADDR_W: destination of the RF instruction.
- id_reg_write, in, 1: RF instruction writes id_rd.
- id_is_load, in, 1: RF instruction is LDUR/LDURB.
- id_src, in, NUM_SRC*REG_ADDR_W: source addresses, operand i at [i*REG_ADDR_W +: REG_ADDR_W].
- id_src_used, in, NUM_SRC: operand i is actually read.
- flush, in, 1: kill the RF instruction (taken branch).
- hold, in, 1: freeze the entire pipeline (e.g. a slow memory).
- stall, out, 1: hold PC and IF/RF registers.
- fwd_sel, out, NUM_SRC*SEL_W, where SEL_W = $clog2(NUM_STAGES+1). 0 = register file; k+1 = result of stage k.
- stage_valid, out, NUM_STAGES: the scoreboard valid bits.
- stall_cnt, out, CNT_W: cycles in which a load-use stall was asserted. Saturating.
- bubble_cnt, out, CNT_W: bubbles entered into stage 0 for any reason. Saturating.

## Operation
- Scoreboard: NUM_STAGES entries of {valid, rd, reg_write, is_load}.
- An entry is "live" when valid & reg_write & rd != ZERO_REG.
- Match for operand i: id_src_used[i], id_valid, and id_src[i] equals the rd of a live entry.
- If several entries match, the lowest index (youngest) wins.
- fwd_sel[i] = winning index + 1, or 0 if there is no match.
- Load-use hazard: the winning entry for any operand has is_load and index < LOAD_READY.
- stall = hazard | hold.
- fwd_sel is driven regardless of stall. The consumer ignores it while stall is high.
- Advance when hold = 0:
  - entry k+1 ← entry k;
  - the last entry is discarded;
  - entry 0 ← the RF instruction if id_valid & ~hazard & ~flush, otherwise a bubble (valid = 0).
- When hold = 1, no entry changes and the counters do not change.
- flush and hazard together: a bubble enters; flush takes priority. stall_cnt still counts the hazard.
- bubble_cnt increments on every advance cycle in which entry 0 receives a bubble.
- Both counters stick at 2^CNT_W−1.

## Timing
- fwd_sel and stall are combinational from the current scoreboard and the id_* inputs, with zero latency.
- The scoreboard updates on the rising edge of clk.
- A load-use hazard holds stall for exactly LOAD_READY cycles when the load sits at index 0. The default is 1 cycle.
- After the stall, the same operand shows fwd_sel = LOAD_READY + 1.
- Reset applies on any clk edge with reset = 1, including mid-stall or mid-hold:
  - all valid bits are cleared and the counters are zeroed;
  - stall = hold and fwd_sel = 0 on the next cycle.
- reset has priority over hold.

## Structure
- Package hazard_pkg holds:
  - the typedef sb_entry_t (valid, rd, reg_write, is_load);
  - function sel_width(NUM_STAGES);
  - the localparam for the bubble entry value.
- One sub-module, sb_match, is instantiated NUM_SRC times. It is a priority matcher producing {hit, index, is_load} for one source operand against the scoreboard.
- The shift register, hazard combine and counters live in hazard_scoreboard itself.

## Test plan
- ADDI X1 followed by ADD X2,X1,X3:
  - cycle 2: fwd_sel[0] = 1, stall = 0.
  - one cycle later, an independent use of X1 sees fwd_sel = 2.
- LDUR X1 followed by ADD X2,X1,X1:
  - stall = 1 for one cycle with fwd_sel[0] = fwd_sel[1] = 1;
  - then stall = 0 with fwd_sel = 2 for both operands;
  - stall_cnt = 1, bubble_cnt = 1.
- Write to X31, then read X31: fwd_sel = 0 and no stall. Same result when id_src_used = 0 for a matching register.
- flush during a load-use hazard:
  - bubble enters and stage_valid[0] = 0 on the next cycle;
  - stall_cnt increments.
- hold = 1 for 3 cycles with a load in stage 0:
  - stage_valid is unchanged and the counters are frozen;
  - the stall releases the cycle after hold falls.
- Assert reset mid-stall:
  - next cycle: stage_valid = 0, stall = 0, both counters = 0.
- With CNT_W = 2, force 5 bubbles: bubble_cnt saturates at 3.
